// File: rtl/ov7670_config_ctrl_if.sv
// SCCB write-request bus between the OV7670 configuration controller and the SCCB sender.
interface ov7670_config_ctrl_if;
   logic       sccb_send;
   logic       sccb_ready;
   logic [7:0] sccb_id;
   logic [7:0] sccb_addr;
   logic [7:0] sccb_data;

   modport master (
      output sccb_send,
      output sccb_id,
      output sccb_addr,
      output sccb_data,
      input  sccb_ready
   );

   modport slave (
      input  sccb_send,
      input  sccb_id,
      input  sccb_addr,
      input  sccb_data,
      output sccb_ready
   );
endinterface

// File: rtl/ov7670_config_ctrl.sv
// Walks the OV7670 register table and issues one SCCB write per entry.
// Entry 16'hFFF0 is a timed delay; 16'hFFFF ends the sequence.
module ov7670_config_ctrl #(
   parameter int unsigned DELAY_CYCLES = 500000,
   parameter logic [7:0]  SCCB_ID      = 8'h42
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [15:0]         command,
   input  logic                finished,
   output logic                resend,
   output logic                advance,
   output logic                busy,
   output logic                config_done,
   output logic [7:0]          write_count,
   ov7670_config_ctrl_if.master sccb
);

   localparam int unsigned CNT_W = $clog2(DELAY_CYCLES + 1);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] REWIND    = 4'd1;
   localparam logic [3:0] FETCH     = 4'd2;
   localparam logic [3:0] DECODE    = 4'd3;
   localparam logic [3:0] SEND      = 4'd4;
   localparam logic [3:0] WAIT_SCCB = 4'd5;
   localparam logic [3:0] DELAY     = 4'd6;
   localparam logic [3:0] ADVANCE   = 4'd7;
   localparam logic [3:0] DONE      = 4'd8;

   logic [3:0]       state_q, state_d;
   logic             step_q, step_d;
   logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
   logic             resend_q, resend_d;
   logic             advance_q, advance_d;
   logic             send_q, send_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       wcount_q, wcount_d;
   logic             send_fire;

   // Next-state and registered-output logic; outputs follow the state being entered.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      wcount_d    = wcount_q;
      send_fire   = 1'b0;

      case (state_q)
         IDLE, DONE: if (start) state_d = REWIND;
         REWIND:     state_d = FETCH;
         FETCH:      if (step_q) state_d = DECODE;
         DECODE: begin
            if (finished)                  state_d = DONE;
            else if (command == 16'hFFF0)  state_d = DELAY;
            else                           state_d = SEND;
         end
         SEND: begin
            if (sccb.sccb_ready) begin
               send_fire = 1'b1;
               state_d   = WAIT_SCCB;
            end
         end
         // the sender only drops ready one cycle after the request, so skip the first look
         WAIT_SCCB:  if (step_q && sccb.sccb_ready) state_d = ADVANCE;
         DELAY:      if (delay_cnt_q == CNT_W'(DELAY_CYCLES - 1)) state_d = ADVANCE;
         ADVANCE:    state_d = FETCH;
         default:    state_d = IDLE;
      endcase

      step_d      = (state_d == state_q);
      delay_cnt_d = (state_q == DELAY && state_d == DELAY) ? delay_cnt_q + CNT_W'(1) : '0;

      if (send_fire) begin
         addr_d = command[15:8];
         data_d = command[7:0];
      end

      if (state_d == REWIND)                   wcount_d = 8'd0;
      else if (send_fire && wcount_q != 8'hFF) wcount_d = wcount_q + 8'd1;

      resend_d  = (state_d == REWIND);
      advance_d = (state_d == ADVANCE);
      send_d    = send_fire;
      busy_d    = (state_d != IDLE) && (state_d != DONE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         step_q      <= 1'b0;
         delay_cnt_q <= '0;
         resend_q    <= 1'b0;
         advance_q   <= 1'b0;
         send_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= 8'd0;
         data_q      <= 8'd0;
         wcount_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         delay_cnt_q <= delay_cnt_d;
         resend_q    <= resend_d;
         advance_q   <= advance_d;
         send_q      <= send_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wcount_q    <= wcount_d;
      end
   end

   assign resend         = resend_q;
   assign advance        = advance_q;
   assign busy           = busy_q;
   assign config_done    = done_q;
   assign write_count    = wcount_q;
   assign sccb.sccb_send = send_q;
   assign sccb.sccb_addr = addr_q;
   assign sccb.sccb_data = data_q;
   assign sccb.sccb_id   = SCCB_ID;

endmodule

// File: doc/ov7670_config_ctrl.md
OV7670_CONFIG_CTRL -- requirements
Module: ov7670_config_ctrl

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 500000, meaning clk cycles spent on a delay command (10 ms at 50 MHz).
REQ-002 SHALL have parameter SCCB_ID, default 8'h42, meaning OV7670 SCCB write ID.
REQ-003 SHALL have port clk  input  1  50 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to (re)run the configuration sequence.
REQ-006 SHALL have port command  input  16  register-table entry {reg_addr[15:8], reg_data[7:0]}.
REQ-007 SHALL have port finished  input  1  register-table end flag (command == 16'hFFFF).
REQ-008 SHALL have port resend  output  1  one-cycle pulse that rewinds the register-table address to 0.
REQ-009 SHALL have port advance  output  1  one-cycle pulse that increments the register-table address.
REQ-010 SHALL have port sccb_send  output  1  one-cycle write request to the SCCB sender.
REQ-011 SHALL have port sccb_ready  input  1  SCCB sender idle; low while a write is in flight.
REQ-012 SHALL have ports sccb_id, sccb_addr, sccb_data  output  8 each  SCCB write ID, register address and register data.
REQ-013 SHALL have port busy  output  1  high while a sequence is in progress.
REQ-014 SHALL have port config_done  output  1  high once the table is exhausted; cleared by the next start.
REQ-015 SHALL have port write_count  output  8  number of SCCB writes issued in the current sequence.

Function
REQ-016 SHALL implement the FSM states IDLE, REWIND, FETCH, DECODE, SEND, WAIT_SCCB, DELAY, ADVANCE and DONE.
REQ-017 In IDLE or DONE with start=1, the FSM SHALL go to REWIND; start SHALL be ignored in every other state.
REQ-018 REWIND SHALL assert resend for exactly 1 cycle, clear write_count and config_done, then go to FETCH.
REQ-019 FETCH SHALL wait exactly 2 cycles (the table has a 2-cycle address-to-command latency), then go to DECODE.
REQ-020 DECODE SHALL go to DONE if finished=1; otherwise to DELAY if command==16'hFFF0; otherwise to SEND. DECODE lasts 1 cycle.
REQ-021 SEND SHALL stall until sccb_ready=1, then in that cycle:
  - assert sccb_send for 1 cycle;
  - drive sccb_addr=command[15:8] and sccb_data=command[7:0];
  - increment write_count (saturating at 255);
  - go to WAIT_SCCB.
REQ-022 sccb_addr and sccb_data SHALL be registered and held stable from the sccb_send cycle until the next sccb_send; sccb_id SHALL be constant SCCB_ID.
REQ-023 WAIT_SCCB SHALL ignore sccb_ready in its first cycle, then wait until sccb_ready=1, then go to ADVANCE.
REQ-024 DELAY SHALL hold for exactly DELAY_CYCLES cycles (counter width ceil(log2(DELAY_CYCLES+1))), then go to ADVANCE; no SCCB write is issued for 16'hFFF0.
REQ-025 ADVANCE SHALL assert advance for exactly 1 cycle, then go to FETCH.
REQ-026 DONE SHALL hold config_done=1 and busy=0, and issue no further advance or sccb_send.
REQ-027 busy SHALL be 1 in every state except IDLE and DONE.
REQ-028 resend, advance and sccb_send SHALL never be asserted in the same cycle, and each SHALL be at most 1 cycle wide.
REQ-029 If start and reset are asserted together, reset SHALL win.

Reset
REQ-030 While reset=1 at a clk edge, the block SHALL enter IDLE and clear resend, advance, sccb_send, busy, config_done, sccb_addr, sccb_data, write_count and the delay counter; sccb_id SHALL remain SCCB_ID.
REQ-031 A reset mid-sequence (including in SEND, WAIT_SCCB or DELAY) SHALL abort immediately; a new start SHALL be required, with no automatic restart.

Verification
REQ-032 Bench SHALL use DELAY_CYCLES=20 and a table model with 2-cycle latency holding {16'h1280, 16'hFFF0, 16'h1200, 16'hFFFF}, plus an SCCB model that drops ready for 5 cycles after each send:
  - start pulse -> 1 resend; writes (12,80) then (12,00); 20-cycle gap with no send between them; write_count=2; config_done=1; busy=0.
REQ-033 sccb_ready held low for 100 cycles in SEND -> no sccb_send until ready rises; sccb_send then asserts in the first cycle ready=1.
REQ-034 reset asserted in the 10th DELAY cycle -> next cycle all outputs are 0 and state is IDLE; no advance follows without a new start.
REQ-035 start pulsed while busy=1 -> ignored (no second resend, sequence unchanged); start pulsed in DONE -> config_done clears, full sequence repeats, write_count ends at 2.
REQ-036 Table that is empty (first entry 16'hFFFF) -> DONE with write_count=0 and no sccb_send or advance.
REQ-037 All runs -> checker confirms REQ-028 pulse-exclusivity and that sccb_addr/sccb_data stay stable while sccb_ready=0.
